hash_light_stream_if: RTL and testbench
=======================================

Name: hash_light_stream_if

Overview:
- Stream adapter that sits in front of and behind the Hash_light_top core.
- Upstream side: accepts a byte stream with valid/ready/last, packs bytes into 4-byte blocks, and zero-pads the final short block of each message.
- Core side: presents each block on the core's m inputs, pulses start, waits for done, and captures the digest d.
- Downstream side: returns each block's 4-byte digest as a byte stream with valid/ready/last. Messages longer than 4 bytes are hashed as independent consecutive blocks.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT before abort; used only when the optional feature is compiled in; legal range 1..65535.

Ports:
clk  in  1  clock, all logic rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
s_data  in  8  input message byte.
s_valid  in  1  s_data valid.
s_last  in  1  byte is the final byte of the message.
s_ready  out  1  adapter accepts a byte this cycle.
core_m  out  4x8 (unpacked [0:3])  block to core; byte 0 is the first byte received.
core_start  out  1  one-cycle start pulse to core.
core_done  in  1  core completion.
core_d  in  4x8 (unpacked [0:3])  core digest, valid when core_done=1.
dg_data  out  8  digest byte, core_d[0] first.
dg_valid  out  1  dg_data valid.
dg_last  out  1  final digest byte of the final block of a message.
dg_ready  in  1  downstream accepts dg_data.
busy  out  1  high in any state other than COLLECT, or when COLLECT holds one or more bytes.
err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the environment's job) forces:
  - state=COLLECT, byte count=0, digest index=0, last-flag=0;
  - core_m all 8'h00, core_start=0, dg_valid=0, dg_last=0, dg_data=8'h00, err_timeout=0.
  - s_ready is 1 in the first cycle after reset release.
  - Reset mid-block/mid-wait/mid-emit drops all held data; no digest is emitted for the interrupted block.
- Handshakes: a transfer occurs on rising edge with valid&ready. dg_data/dg_valid/dg_last stay stable while dg_valid=1 and dg_ready=0. s_valid may be asserted with s_ready=0 without effect.
- FSM states:
  - COLLECT:
    - s_ready=1.
    - Each accepted byte is written to buf[cnt], then cnt++.
    - If the 4th byte is accepted, or s_last is accepted, go to START. The last-flag is registered as s_last.
    - If s_last arrives with cnt<3, bytes cnt+1..3 are set to 8'h00 in the same edge.
  - START: core_start=1 for exactly one cycle; core_m=buf. Next state is WAIT.
  - WAIT:
    - core_start=0.
    - When core_done=1, register core_d into the digest register and go to EMIT.
    - core_done sampled during START is ignored (stale done from a previous run).
  - EMIT:
    - dg_valid=1, dg_data=dig[idx]; dg_last=1 only when idx=3 and last-flag=1.
    - idx advances on each transfer.
    - After the idx=3 transfer: go to COLLECT with cnt=0, idx=0, last-flag=0.
- core_m is held constant from the START cycle through the end of WAIT, regardless of upstream activity, since s_ready=0 outside COLLECT.
- Latency:
  - Accept of the block-completing byte, then core_start is high in the next cycle.
  - core_done sampled, then dg_valid is high in the next cycle.
  - Minimum 4 cycles to drain a digest.
- Message length 5 bytes gives:
  - block 0 = bytes 0..3, with dg_last=0 on its digest;
  - block 1 = {byte4,00,00,00}, with dg_last=1.
- Zero-length messages do not exist, because every beat carries a byte.
- Simultaneous core_done and reset: reset wins.

Optional Feature:
HASH_IF_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no core_done, err_timeout is set. err_timeout stays set until rst_n.
  - The block is discarded (no digest emitted), and the FSM returns to COLLECT with cnt=0.
  - core_done in the same cycle as the terminal count wins: the block completes normally.
- Not defined: no counter; WAIT waits indefinitely; err_timeout is tied to 0.

Test Plan:
The bench core model returns core_done 10 cycles after core_start, with core_d[i] = core_m[i] ^ 8'hA5.
1. Send 4 bytes 01 23 45 67 with last on the 4th → one core_start pulse with core_m = 01 23 45 67; digest stream A4 86 E0 C2, dg_last only on C2.
2. Send 6 bytes 10 20 30 40 50 60 (last on 60) → core_m blocks 10 20 30 40, then 50 60 00 00; digests B5 85 95 E5 (no dg_last), then F5 C5 A5 A5 with dg_last on the final A5.
3. Hold dg_ready=0 for 20 cycles during EMIT → dg_data stays A4 and s_ready stays 0; after release, 4 transfers complete and s_ready returns to 1.
4. Assert rst_n=0 for 1 cycle during WAIT, then send 01 23 45 67 → no digest from the aborted block; a single digest A4 86 E0 C2 follows.
5. Drive core_done=1 stuck in the START cycle, with the real done 10 cycles later → the digest is captured from the real done only.
6. With HASH_IF_TIMEOUT_EN, TIMEOUT_CYCLES=8, and the core never asserting done → err_timeout goes high after the 8th WAIT cycle, no dg_valid, and s_ready=1 in the next cycle. Without the macro, err_timeout stays 0 and the FSM stays in WAIT.

Source files
------------

// File: rtl/hash_light_stream_if.sv
// hash_light_stream_if
// Stream adapter around the Hash_light core. Upstream bytes are packed into
// 4-byte blocks (the final short block of a message is zero-padded), each
// block is handed to the core with a one-cycle start pulse, and the 4-byte
// digest returned by the core is streamed back out byte by byte.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   s_data/s_valid/s_last      upstream message bytes
//   s_ready                    upstream ready (high only while collecting)
//   core_m[0:3], core_start    block and start pulse to the core
//   core_done, core_d[0:3]     completion and digest from the core
//   dg_data/dg_valid/dg_last   digest byte stream, core_d[0] first
//   dg_ready                   downstream ready
//   busy                       not idle (any state but COLLECT, or bytes held)
//   err_timeout                sticky core timeout flag
//   dbg_state                  current FSM state, for observation only
//
// Handshake rule for both streams: a byte moves on a rising clock edge where
// valid and ready are both high; the sender holds data/last/valid unchanged
// while valid is high and ready is low.
//
// Build option: define HASH_IF_TIMEOUT_EN to abort a block when the core has
// not answered within TIMEOUT_CYCLES WAIT cycles. Without it, WAIT waits
// indefinitely and err_timeout is tied low.

module hash_light_stream_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] core_m [0:3],
    output logic       core_start,
    input  logic       core_done,
    input  logic [7:0] core_d [0:3],
    output logic [7:0] dg_data,
    output logic       dg_valid,
    output logic       dg_last,
    input  logic       dg_ready,
    output logic       busy,
    output logic       err_timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        EMIT    = 2'd3
    } state_e;

    state_e     state_q;
    logic [1:0] cnt_q;
    logic [1:0] idx_q;
    logic       last_q;
    logic [7:0] blk_q      [0:3];
    logic [7:0] blk_d      [0:3];
    logic [7:0] core_m_q   [0:3];
    logic [7:0] dig_q      [0:3];
    logic       core_start_q;
    logic       dg_valid_q;
    logic       dg_last_q;
    logic [7:0] dg_data_q;
    logic       tmo_hit;

    // Block contents after accepting the current byte: the byte lands at
    // cnt_q and, when it ends the message, every later slot is cleared.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            blk_d[i] = blk_q[i];
            if (2'(i) == cnt_q) begin
                blk_d[i] = s_data;
            end else if (s_last && (2'(i) > cnt_q)) begin
                blk_d[i] = 8'h00;
            end
        end
    end

`ifdef HASH_IF_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_q;
    logic        err_q;

    // Counter is zero in the first WAIT cycle, so it equals TMO_LAST in the
    // TIMEOUT_CYCLES-th one. A done in that same cycle takes priority.
    assign tmo_hit = (state_q == WAIT) && !core_done && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != WAIT) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            cnt_q        <= 2'd0;
            idx_q        <= 2'd0;
            last_q       <= 1'b0;
            core_start_q <= 1'b0;
            dg_valid_q   <= 1'b0;
            dg_last_q    <= 1'b0;
            dg_data_q    <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                blk_q[i]    <= 8'h00;
                core_m_q[i] <= 8'h00;
                dig_q[i]    <= 8'h00;
            end
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (s_valid) begin
                        blk_q <= blk_d;
                        if ((cnt_q == 2'd3) || s_last) begin
                            // core_m and start are registered together so the
                            // core sees a stable block in the START cycle.
                            core_m_q     <= blk_d;
                            core_start_q <= 1'b1;
                            last_q       <= s_last;
                            cnt_q        <= 2'd0;
                            state_q      <= START;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                START: begin
                    // Any done seen here belongs to a previous run.
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        dig_q      <= core_d;
                        dg_data_q  <= core_d[0];
                        dg_valid_q <= 1'b1;
                        dg_last_q  <= 1'b0;
                        idx_q      <= 2'd0;
                        state_q    <= EMIT;
                    end else if (tmo_hit) begin
                        last_q  <= 1'b0;
                        state_q <= COLLECT;
                    end
                end
                EMIT: begin
                    if (dg_ready) begin
                        if (idx_q == 2'd3) begin
                            dg_valid_q <= 1'b0;
                            dg_last_q  <= 1'b0;
                            idx_q      <= 2'd0;
                            last_q     <= 1'b0;
                            state_q    <= COLLECT;
                        end else begin
                            idx_q     <= idx_q + 2'd1;
                            dg_data_q <= dig_q[idx_q + 2'd1];
                            dg_last_q <= (idx_q == 2'd2) && last_q;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign s_ready    = (state_q == COLLECT);
    assign core_m     = core_m_q;
    assign core_start = core_start_q;
    assign dg_data    = dg_data_q;
    assign dg_valid   = dg_valid_q;
    assign dg_last    = dg_last_q;
    assign busy       = (state_q != COLLECT) || (cnt_q != 2'd0);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hash_light_stream_if.sv
`timescale 1ns/1ps

module tb_hash_light_stream_if;

    // ---------------------------------------------------------------- signals
    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] core_m [0:3];
    logic       core_start;
    logic       core_done;
    logic [7:0] core_d [0:3];
    logic [7:0] dg_data;
    logic       dg_valid;
    logic       dg_last;
    logic       dg_ready;
    logic       busy;
    logic       err_timeout;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];       // {last, byte} expected digest stream
    logic [8:0]  got_q[$];
    logic [31:0] exp_blk_q[$];   // expected core_m blocks, byte 0 in MSBs
    logic [31:0] got_blk_q[$];

    logic [7:0] msg [0:15];
    logic [7:0] core_hold [0:3];
    int         core_cd   = 0;
    bit         core_mute = 0;
    bit         stale_done = 0;
    int         rdy_mode  = 0;   // 0 always ready, 1 random, 2 stalled

    hash_light_stream_if #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .core_m      (core_m),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_d      (core_d),
        .dg_data     (dg_data),
        .dg_valid    (dg_valid),
        .dg_last     (dg_last),
        .dg_ready    (dg_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    // ------------------------------------------------------ clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------ core model
    // Answers 10 cycles after each start with core_d[i] = core_m[i] ^ A5.
    always @(negedge clk) begin
        if (!rst_n) begin
            core_cd   = 0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (core_start) begin
                got_blk_q.push_back({core_m[0], core_m[1], core_m[2], core_m[3]});
                for (int i = 0; i < 4; i++) core_hold[i] = core_m[i] ^ 8'hA5;
                core_cd = 10;
                if (stale_done) begin
                    core_done = 1'b1;
                    for (int i = 0; i < 4; i++) core_d[i] = 8'hFF;
                end
            end else if (core_cd > 0) begin
                core_cd = core_cd - 1;
                if (core_cd == 0 && !core_mute) begin
                    core_done = 1'b1;
                    core_d    = core_hold;
                end
            end
        end
    end

    // Downstream ready driver and digest capture: a byte is recorded when
    // valid and ready are both high ahead of the next rising edge.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       dg_ready = 1'b1;
            1:       dg_ready = 1'($urandom_range(0, 1));
            default: dg_ready = 1'b0;
        endcase
        if (rst_n && dg_valid && dg_ready) got_q.push_back({dg_last, dg_data});
    end

    // ---------------------------------------------------------- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: split into 4-byte blocks, zero-pad the tail, digest = byte ^ A5,
    // last marks byte 3 of the final block only.
    task automatic model_msg(input int len);
        int nblk;
        logic [31:0] w;
        logic [7:0] v;
        nblk = (len + 3) / 4;
        for (int b = 0; b < nblk; b++) begin
            w = 32'h0;
            for (int i = 0; i < 4; i++) begin
                v = (4 * b + i < len) ? msg[4 * b + i] : 8'h00;
                w = {w[23:0], v};
                exp_q.push_back({(b == nblk - 1) && (i == 3), v ^ 8'hA5});
            end
            exp_blk_q.push_back(w);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_dg_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_dg"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
        check({tag, "_blk_count"}, 32'(got_blk_q.size()), 32'(exp_blk_q.size()));
        for (int i = 0; i < exp_blk_q.size(); i++)
            check({tag, "_core_m"}, (i < got_blk_q.size()) ? got_blk_q[i] : 32'hxxxxxxxx, exp_blk_q[i]);
        exp_q.delete();
        got_q.delete();
        exp_blk_q.delete();
        got_blk_q.delete();
    endtask

    // ------------------------------------------------------------ drivers
    // Starts and ends on a falling edge; on return the last byte has been taken.
    task automatic send_msg(input int len, input bit gaps);
        bit acc;
        int guard;
        for (int k = 0; k < len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = msg[k];
            s_last  = (k == len - 1);
            guard   = 0;
            do begin
                acc = s_ready;
                @(negedge clk);
                guard++;
            end while (!acc && guard < 300);
            if (!acc) begin
                check("send_accept", 32'(acc), 32'd1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_digests(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() < n) check("dg_wait", 32'(got_q.size()), 32'(n));
        @(negedge clk);
    endtask

    task automatic set4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        msg[0] = a; msg[1] = b; msg[2] = c; msg[3] = d;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        int len;
        int k;
        rst_n = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        dg_ready = 1'b1; core_done = 1'b0;
        for (int i = 0; i < 4; i++) core_d[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_dg_valid", 32'(dg_valid), 32'd0);
        check("rst_dg_last", 32'(dg_last), 32'd0);
        check("rst_dg_data", 32'(dg_data), 32'h00);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_m", {core_m[0], core_m[1], core_m[2], core_m[3]}, 32'h0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: single full block, latency of start and digest
        set4(8'h01, 8'h23, 8'h45, 8'h67);
        model_msg(4);
        send_msg(4, 0);
        check("t1_start_latency", 32'(core_start), 32'd1);
        check("t1_core_m", {core_m[0], core_m[1], core_m[2], core_m[3]}, 32'h01234567);
        repeat (10) @(negedge clk);
        check("t1_dg_before_done", 32'(dg_valid), 32'd0);
        @(negedge clk);
        check("t1_dg_valid", 32'(dg_valid), 32'd1);
        check("t1_dg_first", 32'(dg_data), 32'hA4);
        wait_digests(4, 50);
        compare_all("t1");

        // 2: six-byte message over two blocks
        msg[0] = 8'h10; msg[1] = 8'h20; msg[2] = 8'h30;
        msg[3] = 8'h40; msg[4] = 8'h50; msg[5] = 8'h60;
        model_msg(6);
        fork
            send_msg(6, 0);
            wait_digests(8, 400);
        join
        compare_all("t2");

        // 3: downstream stall holds the first digest byte
        rdy_mode = 2;
        set4(8'h01, 8'h23, 8'h45, 8'h67);
        model_msg(4);
        send_msg(4, 0);
        k = 0;
        while (!dg_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t3_dg_valid", 32'(dg_valid), 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t3_hold_data", 32'(dg_data), 32'hA4);
            check("t3_hold_valid", 32'(dg_valid), 32'd1);
            check("t3_hold_s_ready", 32'(s_ready), 32'd0);
        end
        rdy_mode = 0;
        wait_digests(4, 50);
        check("t3_s_ready_back", 32'(s_ready), 32'd1);
        compare_all("t3");

        // 4: reset while waiting on the core drops the block
        set4(8'h01, 8'h23, 8'h45, 8'h67);
        send_msg(4, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("t4_core_m_cleared", {core_m[0], core_m[1], core_m[2], core_m[3]}, 32'h0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_s_ready", 32'(s_ready), 32'd1);
        check("t4_aborted_starts", 32'(got_blk_q.size()), 32'd1);
        got_blk_q.delete();
        model_msg(4);
        send_msg(4, 0);
        wait_digests(4, 50);
        repeat (15) @(negedge clk);
        compare_all("t4");

        // 5: stale done during START must be ignored
        set4(8'h3C, 8'h00, 8'hFF, 8'h81);
        model_msg(4);
        stale_done = 1;
        send_msg(4, 0);
        @(negedge clk);
        stale_done = 0;
        check("t5_no_early_dg", 32'(dg_valid), 32'd0);
        wait_digests(4, 50);
        compare_all("t5");

        // Random messages with idle gaps and random downstream ready
        rdy_mode = 1;
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            model_msg(len);
            fork
                send_msg(len, 1);
                wait_digests(4 * ((len + 3) / 4), 800);
            join
            compare_all("rand");
        end
        rdy_mode = 0;

        // 6: core never answers
        core_mute = 1;
        set4(8'h11, 8'h22, 8'h33, 8'h44);
        send_msg(4, 0);
`ifdef HASH_IF_TIMEOUT_EN
        repeat (8) @(negedge clk);
        check("t6_err_before", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("t6_err_set", 32'(err_timeout), 32'd1);
        check("t6_s_ready", 32'(s_ready), 32'd1);
        repeat (15) @(negedge clk);
        check("t6_err_sticky", 32'(err_timeout), 32'd1);
        check("t6_no_dg", 32'(got_q.size()), 32'd0);
        check("t6_dg_valid", 32'(dg_valid), 32'd0);
`else
        repeat (30) @(negedge clk);
        check("t6_err_tied", 32'(err_timeout), 32'd0);
        check("t6_still_waiting", 32'(s_ready), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_no_dg", 32'(got_q.size()), 32'd0);
`endif
        core_mute = 0;
        do_reset(1);
        check("t6_err_after_reset", 32'(err_timeout), 32'd0);
        check("t6_ready_after_reset", 32'(s_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
